crt_clock_synth: RTL and testbench

//  Runtime-configurable pixel-clock generator for the VGA/Pong datapath. It supersedes the fixed 25 MHz CRT divider.

---
 rtl/crt_clock_synth.sv | 172 +++++++++++++++++
 tb/tb_crt_clock_synth.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/crt_clock_synth.sv
// crt_clock_synth: runtime-configurable pixel-clock generator.
// Produces CRTclock plus a one-cycle CRTtick enable from Clock. It has two modes:
// integer divide (N = floor(S/T), near-50% duty) and a fractional phase
// accumulator (exact average rate). Reconfiguration goes through a Load/LoadAck
// handshake that never truncates a high phase.
module crt_clock_synth #(
  parameter int SystemClockSize = 10,
  parameter int TargetSize      = 10
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic [SystemClockSize-1:0] SystemClock,
  input  logic [TargetSize-1:0]      TargetClock,
  input  logic                       Mode,
  input  logic                       Load,
  output logic                       LoadAck,
  output logic                       CRTclock,
  output logic                       CRTtick,
  output logic                       Locked,
  output logic                       ConfigError
);

  localparam int W = SystemClockSize;
  localparam logic [W-1:0] ONE  = 1;
  localparam logic [W-1:0] LAST = W - 1;

  localparam logic [2:0] CAPTURE = 3'd0;
  localparam logic [2:0] CHECK   = 3'd1;
  localparam logic [2:0] DIVIDE  = 3'd2;
  localparam logic [2:0] RUN     = 3'd3;
  localparam logic [2:0] WAITLOW = 3'd4;
  localparam logic [2:0] ERROR   = 3'd5;

  logic [2:0]   state;
  logic [W-1:0] s_q;
  logic [W-1:0] t_q;
  logic         m_q;
  logic [W-1:0] rem;
  logic [W-1:0] quo;   // dividend shift register during DIVIDE, then N
  logic [W-1:0] cnt;   // divide step counter, then phase counter in RUN
  logic [W:0]   acc;

  logic         illegal;
  logic [W:0]   trial;
  logic         ge;
  logic [W-1:0] rem_nxt;
  logic [W-1:0] quo_nxt;
  logic [W:0]   half;
  logic [W-1:0] cnt_nxt;
  logic [W:0]   sum;
  logic         wrap;
  logic [W:0]   acc_nxt;
  logic         clk_nxt;

  // Config legality, one restoring-divide step, and next waveform value for both modes
  always_comb begin
    illegal = (s_q == '0) || (t_q == '0) || ({t_q, 1'b0} > {1'b0, s_q});

    trial   = {rem, quo[W-1]};
    ge      = trial >= {1'b0, t_q};
    rem_nxt = ge ? (trial[W-1:0] - t_q) : trial[W-1:0];
    quo_nxt = {quo[W-2:0], ge};

    // High for ceil(N/2) cycles of each N-cycle period
    half    = ({1'b0, quo} + {{W{1'b0}}, 1'b1}) >> 1;
    cnt_nxt = (cnt == quo - ONE) ? '0 : cnt + ONE;

    // Accumulator stays below S, so acc + 2T < 2S fits in W+1 bits
    sum     = acc + {t_q, 1'b0};
    wrap    = sum >= {1'b0, s_q};
    acc_nxt = wrap ? (sum - {1'b0, s_q}) : sum;

    if (m_q) clk_nxt = wrap ? ~CRTclock : CRTclock;
    else     clk_nxt = {1'b0, cnt} < half;
  end

  // Control FSM, divider, waveform generator and registered outputs
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= CAPTURE;
      s_q         <= '0;
      t_q         <= '0;
      m_q         <= 1'b0;
      rem         <= '0;
      quo         <= '0;
      cnt         <= '0;
      acc         <= '0;
      LoadAck     <= 1'b0;
      CRTclock    <= 1'b0;
      CRTtick     <= 1'b0;
      Locked      <= 1'b0;
      ConfigError <= 1'b0;
    end else begin
      LoadAck <= 1'b0;
      CRTtick <= 1'b0;
      case (state)
        CAPTURE: begin
          s_q      <= SystemClock;
          t_q      <= W'(TargetClock);
          m_q      <= Mode;
          LoadAck  <= 1'b1;
          CRTclock <= 1'b0;
          Locked   <= 1'b0;
          state    <= CHECK;
        end
        CHECK: begin
          if (Load) begin
            state <= CAPTURE;
          end else if (illegal) begin
            ConfigError <= 1'b1;
            state       <= ERROR;
          end else begin
            rem   <= '0;
            quo   <= s_q;
            cnt   <= '0;
            acc   <= '0;
            state <= m_q ? RUN : DIVIDE;
          end
        end
        DIVIDE: begin
          if (Load) begin
            state <= CAPTURE;
          end else begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            if (cnt == LAST) begin
              cnt   <= '0;
              acc   <= '0;
              state <= RUN;
            end else begin
              cnt <= cnt + ONE;
            end
          end
        end
        RUN: begin
          cnt <= cnt_nxt;
          acc <= acc_nxt;
          if (Load) begin
            Locked <= 1'b0;
            if (CRTclock) begin
              // Let the current high phase finish before recapturing
              CRTclock <= clk_nxt;
              state    <= WAITLOW;
            end else begin
              state <= CAPTURE;
            end
          end else begin
            CRTclock <= clk_nxt;
            CRTtick  <= clk_nxt & ~CRTclock;
            Locked   <= 1'b1;
          end
        end
        WAITLOW: begin
          cnt      <= cnt_nxt;
          acc      <= acc_nxt;
          CRTclock <= clk_nxt;
          if (!clk_nxt) state <= CAPTURE;
        end
        ERROR: begin
          CRTclock <= 1'b0;
          Locked   <= 1'b0;
          if (Load) begin
            ConfigError <= 1'b0;
            state       <= CAPTURE;
          end
        end
        default: state <= CAPTURE;
      endcase
    end
  end

endmodule

// File: tb/tb_crt_clock_synth.sv
// Directed testbench for crt_clock_synth.
// Outputs are sampled on the falling edge. Cycle k counts rising edges after
// reset release, or after the cycle in which LoadAck was seen (that cycle is k=1).
module tb_crt_clock_synth;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] sysclk;
  logic [9:0] tgtclk;
  logic       mode;
  logic       load;
  logic       loadack, crtclock, crttick, locked, cfgerr;

  int n_cmp = 0;
  int n_bad = 0;

  crt_clock_synth #(.SystemClockSize(10), .TargetSize(10)) dut (
    .Clock(clk), .Reset(rst), .SystemClock(sysclk), .TargetClock(tgtclk),
    .Mode(mode), .Load(load), .LoadAck(loadack), .CRTclock(crtclock),
    .CRTtick(crttick), .Locked(locked), .ConfigError(cfgerr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Request a new configuration and wait (bounded) for LoadAck
  task automatic do_load(input int s, input int t, input bit m, output bit ok);
    sysclk = 10'(s);
    tgtclk = 10'(t);
    mode   = m;
    load   = 1'b1;
    ok     = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (loadack === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    load = 1'b0;
  endtask

  // Integer-mode waveform from cycle kstart to kend: lock at k=13, period n
  task automatic test_int_wave(input string nm, input int kstart, input int kend, input int n);
    logic [4:0] got, exp;
    bit lk, eclk, etk;
    int ph, hi;
    hi = (n + 1) / 2;
    for (int k = kstart; k <= kend; k++) begin
      @(negedge clk);
      lk   = (k >= 13);
      ph   = k - 13;
      eclk = lk && ((ph % n) < hi);
      etk  = lk && ((ph % n) == 0);
      exp  = {(k == 1), eclk, etk, lk, 1'b0};
      got  = {loadack, crtclock, crttick, locked, cfgerr};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL %s k=%0d {ack,clk,tick,lock,err} got=%b exp=%b", nm, k, got, exp);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; sysclk = 10'd100; tgtclk = 10'd25; mode = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({loadack, crtclock, crttick, locked, cfgerr} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_outputs got=%b exp=00000", {loadack, crtclock, crttick, locked, cfgerr});
    end
    rst = 1'b0;
    test_int_wave("div4_after_reset", 1, 26, 4);
  endtask

  task automatic test_ignore_inputs();
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (crttick === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL ignore_tick_wait got=no tick exp=tick"); end
    sysclk = 10'd7; tgtclk = 10'd3; mode = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({crtclock, crttick, locked} !== {((k % 4) < 2), ((k % 4) == 0), 1'b1}) begin
        n_bad++;
        $display("FAIL ignore_inputs k=%0d {clk,tick,lock} got=%b%b%b", k, crtclock, crttick, locked);
      end
    end
  endtask

  task automatic test_div3();
    bit ok;
    do_load(100, 33, 1'b0, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL div3_loadack got=timeout exp=ack"); end
    test_int_wave("div3", 2, 27, 3);
  endtask

  task automatic test_frac();
    bit ok;
    int c1 = 0, c2 = 0, last = -1, badsp = 0, first = -1;
    do_load(50, 20, 1'b1, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL frac_loadack got=timeout exp=ack"); end
    @(negedge clk);
    n_cmp++;
    if (locked !== 1'b0) begin n_bad++; $display("FAIL frac_lock_k2 got=%b exp=0", locked); end
    for (int k = 3; k <= 102; k++) begin
      if (k > 3 || k == 3) @(negedge clk);
      if (k == 3) begin
        n_cmp++;
        if (locked !== 1'b1) begin n_bad++; $display("FAIL frac_lock_k3 got=%b exp=1", locked); end
      end
      if (crttick === 1'b1) begin
        if (k <= 52) c1++; else c2++;
        if (first < 0) first = k;
        if (last >= 0 && !((k - last) == 2 || (k - last) == 3)) badsp++;
        last = k;
      end
    end
    n_cmp++;
    if (first !== 4) begin n_bad++; $display("FAIL frac_first_tick got=%0d exp=4", first); end
    n_cmp++;
    if (c1 !== 20) begin n_bad++; $display("FAIL frac_window1 got=%0d exp=20", c1); end
    n_cmp++;
    if (c2 !== 20) begin n_bad++; $display("FAIL frac_window2 got=%0d exp=20", c2); end
    n_cmp++;
    if (badsp !== 0) begin n_bad++; $display("FAIL frac_spacing bad=%0d exp=0", badsp); end
  endtask

  task automatic test_error();
    bit ok;
    int s_tab[3] = '{100, 100, 0};
    int t_tab[3] = '{60, 0, 25};
    for (int c = 0; c < 3; c++) begin
      do_load(s_tab[c], t_tab[c], 1'b0, ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL err%0d_loadack got=timeout exp=ack", c); end
      for (int k = 2; k <= 6; k++) begin
        @(negedge clk);
        n_cmp++;
        if ({cfgerr, crtclock, crttick, locked} !== 4'b1000) begin
          n_bad++;
          $display("FAIL err%0d k=%0d {err,clk,tick,lock} got=%b exp=1000", c, k,
                   {cfgerr, crtclock, crttick, locked});
        end
      end
    end
    do_load(100, 25, 1'b0, ok);
    n_cmp++;
    if (!ok || cfgerr !== 1'b0) begin
      n_bad++;
      $display("FAIL err_recover_ack ok=%0d err=%b exp ok=1 err=0", ok, cfgerr);
    end
    test_int_wave("err_recover_div4", 2, 26, 4);
  endtask

  task automatic test_reconfig_waitlow();
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (crttick === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL waitlow_tick_wait got=no tick exp=tick"); end
    tgtclk = 10'd10;
    load   = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({crtclock, locked, loadack} !== 3'b100) begin
      n_bad++;
      $display("FAIL waitlow_high2 {clk,lock,ack} got=%b exp=100", {crtclock, locked, loadack});
    end
    @(negedge clk);
    n_cmp++;
    if ({crtclock, loadack} !== 2'b00) begin
      n_bad++;
      $display("FAIL waitlow_fall {clk,ack} got=%b exp=00", {crtclock, loadack});
    end
    @(negedge clk);
    n_cmp++;
    if ({crtclock, loadack} !== 2'b01) begin
      n_bad++;
      $display("FAIL waitlow_ack {clk,ack} got=%b exp=01", {crtclock, loadack});
    end
    load = 1'b0;
    test_int_wave("div10", 2, 45, 10);
  endtask

  task automatic test_reset_mid_divide();
    bit ok;
    do_load(100, 25, 1'b0, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL rstdiv_loadack got=timeout exp=ack"); end
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({loadack, crtclock, crttick, locked, cfgerr} !== 5'b0) begin
      n_bad++;
      $display("FAIL rst_mid_divide got=%b exp=00000", {loadack, crtclock, crttick, locked, cfgerr});
    end
    @(negedge clk);
    rst = 1'b0;
    test_int_wave("rstdiv_restart", 1, 20, 4);
  endtask

  task automatic test_reset_mid_run();
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (crtclock === 1'b1 && locked === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL rstrun_high_wait got=never high exp=high"); end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({loadack, crtclock, crttick, locked, cfgerr} !== 5'b0) begin
      n_bad++;
      $display("FAIL rst_mid_run got=%b exp=00000", {loadack, crtclock, crttick, locked, cfgerr});
    end
    @(negedge clk);
    rst = 1'b0;
    test_int_wave("rstrun_restart", 1, 20, 4);
  endtask

  initial begin
    test_reset();
    test_ignore_inputs();
    sysclk = 10'd100; tgtclk = 10'd25; mode = 1'b0;
    test_div3();
    test_frac();
    test_error();
    test_reconfig_waitlow();
    test_reset_mid_divide();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
